// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the MEM-stage exception arbiter.
package exc_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] EXC_INT  = 32'h0000_0001;
    localparam logic [XLEN-1:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [XLEN-1:0] EXC_ADES = 32'h0000_0005;
    localparam logic [XLEN-1:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [XLEN-1:0] EXC_BP   = 32'h0000_0009;
    localparam logic [XLEN-1:0] EXC_RI   = 32'h0000_000a;
    localparam logic [XLEN-1:0] EXC_OV   = 32'h0000_000c;
    localparam logic [XLEN-1:0] EXC_TR   = 32'h0000_000d;
    localparam logic [XLEN-1:0] EXC_ERET = 32'h0000_000e;

    localparam int unsigned STATUS_IE  = 0;
    localparam int unsigned STATUS_EXL = 1;
    localparam int unsigned IM_HI      = 15;
    localparam int unsigned IM_LO      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } exc_state_e;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic trap;
        logic syscall;
        logic brk;
        logic eret;
        logic adel_ld;
        logic ades;
    } exc_flags_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception selector: detection, code and faulting address.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic            valid_i,
    input  logic            int_p_i,
    input  exc_flags_t      flags_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] addr_i,
    output logic            det_o,
    output logic [XLEN-1:0] code_o,
    output logic [XLEN-1:0] bad_addr_o
);

    assign det_o = valid_i & (int_p_i | (|flags_i));

    always_comb begin
        code_o     = '0;
        bad_addr_o = '0;
        if (int_p_i) begin
            code_o = EXC_INT;
        end else if (flags_i.adel_if) begin
            code_o     = EXC_ADEL;
            bad_addr_o = pc_i;
        end else if (flags_i.ri) begin
            code_o = EXC_RI;
        end else if (flags_i.ov) begin
            code_o = EXC_OV;
        end else if (flags_i.trap) begin
            code_o = EXC_TR;
        end else if (flags_i.syscall) begin
            code_o = EXC_SYS;
        end else if (flags_i.brk) begin
            code_o = EXC_BP;
        end else if (flags_i.eret) begin
            code_o = EXC_ERET;
        end else if (flags_i.adel_ld) begin
            code_o     = EXC_ADEL;
            bad_addr_o = addr_i;
        end else if (flags_i.ades) begin
            code_o     = EXC_ADES;
            bad_addr_o = addr_i;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception arbiter: capture, drain the data bus, then one-cycle commit to CP0.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned DRAIN_MAX  = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic        mem_adel_if_i,
    input  logic        mem_ri_i,
    input  logic        mem_ov_i,
    input  logic        mem_trap_i,
    input  logic        mem_syscall_i,
    input  logic        mem_break_i,
    input  logic        mem_eret_i,
    input  logic        mem_adel_ld_i,
    input  logic        mem_ades_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        dbus_busy_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic [31:0] newpc_o
);

    exc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   code_q, code_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   bad_q, bad_d;
    logic              ds_q, ds_d;
    logic              eret_q, eret_d;

    logic              int_p;
    logic              det;
    logic [XLEN-1:0]   enc_code;
    logic [XLEN-1:0]   enc_bad;
    exc_flags_t        flags;
    logic              unused_cp0_bits;

    assign int_p = cp0_status_i[STATUS_IE] & ~cp0_status_i[STATUS_EXL]
                 & (|(cp0_cause_i[IM_HI:IM_LO] & cp0_status_i[IM_HI:IM_LO]));

    assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                               cp0_cause_i[31:16], cp0_cause_i[7:0]};

    assign flags = '{adel_if: mem_adel_if_i, ri: mem_ri_i, ov: mem_ov_i,
                     trap: mem_trap_i, syscall: mem_syscall_i, brk: mem_break_i,
                     eret: mem_eret_i, adel_ld: mem_adel_ld_i, ades: mem_ades_i};

    exc_prio_enc u_prio_enc (
        .valid_i    (mem_valid_i),
        .int_p_i    (int_p),
        .flags_i    (flags),
        .pc_i       (mem_pc_i),
        .addr_i     (mem_addr_i),
        .det_o      (det),
        .code_o     (enc_code),
        .bad_addr_o (enc_bad)
    );

    // State and capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            pc_q    <= '0;
            bad_q   <= '0;
            ds_q    <= 1'b0;
            eret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
            ds_q    <= ds_d;
            eret_q  <= eret_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d             = state_q;
        cnt_d               = cnt_q;
        code_d              = code_q;
        pc_d                = pc_q;
        bad_d               = bad_q;
        ds_d                = ds_q;
        eret_d              = eret_q;
        excepttype_o        = '0;
        current_inst_addr_o = '0;
        is_in_delayslot_o   = 1'b0;
        bad_addr_o          = '0;
        flush_o             = 1'b0;
        stall_o             = 1'b0;
        newpc_o             = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Gated by reset so every output reads 0 while rst_n is low.
                stall_o = rst_n & det;
                if (det) begin
                    code_d  = enc_code;
                    pc_d    = mem_pc_i;
                    ds_d    = mem_in_delayslot_i;
                    bad_d   = enc_bad;
                    eret_d  = (enc_code == EXC_ERET);
                    cnt_d   = '0;
                    state_d = dbus_busy_i ? ST_DRAIN : ST_COMMIT;
                end
            end
            ST_DRAIN: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (!dbus_busy_i || (cnt_q == CNT_W'(DRAIN_MAX - 1))) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                excepttype_o        = code_q;
                current_inst_addr_o = pc_q;
                is_in_delayslot_o   = ds_q;
                bad_addr_o          = bad_q;
                flush_o             = 1'b1;
                newpc_o             = eret_q ? cp0_epc_i : EXC_VECTOR;
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
